// File: rtl/eth_rx_ext_fifo_shim.sv
// Store-and-forward shim between a MAC RX byte stream (no backpressure) and an RX FIFO input.
// Optional ETH_RX_SHIM_STATS_EN adds good/dropped frame counters.
module eth_rx_ext_fifo_shim #(
    parameter int unsigned DEPTH          = 2048,
    parameter bit          DROP_BAD_FRAME = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        status_overflow,
    output logic        status_bad_frame,
    output logic        status_good_frame
`ifdef ETH_RX_SHIM_STATS_EN
    ,
    output logic [31:0] stat_good_frames,
    output logic [31:0] stat_drop_frames
`endif
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned WORD_W = 10;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_DROP   = 1'b1
    } wr_state_e;

    wr_state_e          state_q, state_d;
    logic [PTR_W-1:0]   wr_cur_q, wr_cur_d;
    logic [PTR_W-1:0]   wr_commit_q, wr_commit_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [PTR_W-1:0]   rd_fetch_q, rd_fetch_d;
    logic               ram_vld_q, ram_vld_d;
    logic               out_vld_q, out_vld_d;
    logic [WORD_W-1:0]  out_word_q, out_word_d;
    logic               skid_vld_q, skid_vld_d;
    logic [WORD_W-1:0]  skid_word_q, skid_word_d;
    logic               ovf_q, ovf_d;
    logic               bad_q, bad_d;
    logic               good_q, good_d;

    logic [WORD_W-1:0]  mem [DEPTH];
    logic [WORD_W-1:0]  ram_dout_q;

    logic               full_c;
    logic               empty_c;
    logic               pop_c;
    logic               rd_issue_c;
    logic               mem_we_c;
    logic               discard_c;
    logic [1:0]         occ_c;

`ifdef ETH_RX_SHIM_STATS_EN
    logic [31:0]        stat_good_q, stat_good_d;
    logic [31:0]        stat_drop_q, stat_drop_d;
`endif

    // rd_q is released only on output handshake, so bytes held in the read pipeline still occupy space
    assign full_c     = (wr_cur_q - rd_q) == PTR_W'(DEPTH);
    assign empty_c    = rd_fetch_q == wr_commit_q;
    assign pop_c      = out_vld_q && m_axis_tready;
    assign occ_c      = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(ram_vld_q);
    assign rd_issue_c = !empty_c && ((occ_c - 2'(pop_c)) < 2'd2);

    always_comb begin
        state_d     = state_q;
        wr_cur_d    = wr_cur_q;
        wr_commit_d = wr_commit_q;
        rd_d        = rd_q + PTR_W'(pop_c);
        rd_fetch_d  = rd_fetch_q + PTR_W'(rd_issue_c);
        ram_vld_d   = rd_issue_c;
        out_vld_d   = out_vld_q;
        out_word_d  = out_word_q;
        skid_vld_d  = skid_vld_q;
        skid_word_d = skid_word_q;
        ovf_d       = 1'b0;
        bad_d       = 1'b0;
        good_d      = 1'b0;
        mem_we_c    = 1'b0;
        discard_c   = 1'b0;

        if (s_axis_tvalid) begin
            case (state_q)
                ST_ACTIVE: begin
                    if (full_c) begin
                        ovf_d    = 1'b1;
                        bad_d    = s_axis_tlast && s_axis_tuser;
                        wr_cur_d = wr_commit_q;
                        state_d  = s_axis_tlast ? ST_ACTIVE : ST_DROP;
                    end else begin
                        mem_we_c = 1'b1;
                        wr_cur_d = wr_cur_q + PTR_W'(1);
                        if (s_axis_tlast) begin
                            bad_d = s_axis_tuser;
                            if (s_axis_tuser && DROP_BAD_FRAME) begin
                                wr_cur_d  = wr_commit_q;
                                discard_c = 1'b1;
                            end else begin
                                wr_commit_d = wr_cur_q + PTR_W'(1);
                                good_d      = !s_axis_tuser;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (s_axis_tlast) begin
                        state_d = ST_ACTIVE;
                        bad_d   = s_axis_tuser;
                    end
                end
                default: state_d = ST_ACTIVE;
            endcase
        end

        // Output reg drains first, then skid refills it, then the RAM word lands in the free slot
        if (pop_c) begin
            out_vld_d  = skid_vld_q;
            out_word_d = skid_vld_q ? skid_word_q : out_word_q;
            skid_vld_d = 1'b0;
        end
        if (ram_vld_q) begin
            if (!out_vld_d) begin
                out_vld_d  = 1'b1;
                out_word_d = ram_dout_q;
            end else begin
                skid_vld_d  = 1'b1;
                skid_word_d = ram_dout_q;
            end
        end
    end

`ifdef ETH_RX_SHIM_STATS_EN
    always_comb begin
        stat_good_d = stat_good_q + 32'(good_d);
        stat_drop_d = stat_drop_q + 32'(ovf_d || discard_c);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACTIVE;
            wr_cur_q    <= '0;
            wr_commit_q <= '0;
            rd_q        <= '0;
            rd_fetch_q  <= '0;
            ram_vld_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            out_word_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_word_q <= '0;
            ovf_q       <= 1'b0;
            bad_q       <= 1'b0;
            good_q      <= 1'b0;
`ifdef ETH_RX_SHIM_STATS_EN
            stat_good_q <= '0;
            stat_drop_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_cur_q    <= wr_cur_d;
            wr_commit_q <= wr_commit_d;
            rd_q        <= rd_d;
            rd_fetch_q  <= rd_fetch_d;
            ram_vld_q   <= ram_vld_d;
            out_vld_q   <= out_vld_d;
            out_word_q  <= out_word_d;
            skid_vld_q  <= skid_vld_d;
            skid_word_q <= skid_word_d;
            ovf_q       <= ovf_d;
            bad_q       <= bad_d;
            good_q      <= good_d;
`ifdef ETH_RX_SHIM_STATS_EN
            stat_good_q <= stat_good_d;
            stat_drop_q <= stat_drop_d;
`endif
        end
    end

    // Frame buffer: reads only touch committed entries, so they never collide with the write address
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[wr_cur_q[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tuser && s_axis_tlast, s_axis_tdata};
        end
        if (rd_issue_c) begin
            ram_dout_q <= mem[rd_fetch_q[ADDR_W-1:0]];
        end
    end

    assign m_axis_tvalid     = out_vld_q;
    assign m_axis_tdata      = out_word_q[7:0];
    assign m_axis_tuser      = out_word_q[8];
    assign m_axis_tlast      = out_word_q[9];
    assign status_overflow   = ovf_q;
    assign status_bad_frame  = bad_q;
    assign status_good_frame = good_q;
`ifdef ETH_RX_SHIM_STATS_EN
    assign stat_good_frames  = stat_good_q;
    assign stat_drop_frames  = stat_drop_q;
`endif

endmodule

// File: tb/tb_eth_rx_ext_fifo_shim.sv
// Directed scoreboard bench for eth_rx_ext_fifo_shim (DEPTH=64 keep-bad instance, DEPTH=2048 drop-bad instance).
module tb_eth_rx_ext_fifo_shim;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tvalid_b = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic        tready_man = 1'b0;
    logic        toggle_en = 1'b0;
    logic        tgl = 1'b0;
    logic        m_tready;

    logic [7:0]  m_tdata, b_tdata;
    logic        m_tvalid, m_tlast, m_tuser, ovf, bad, good;
    logic        b_tvalid, b_tlast, b_tuser, b_ovf, b_bad, b_good;
`ifdef ETH_RX_SHIM_STATS_EN
    logic [31:0] st_good, st_drop, b_st_good, b_st_drop;
`endif

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [9:0]  sb[$];
    int          n_good = 0, n_bad = 0, n_ovf = 0, b_beats = 0, b_bad_n = 0;
    int          rise_cyc = -1, ovf_cyc = -1, mark_cyc = -1, tlast_cyc = -1;
    logic        stall_prev = 1'b0, vld_prev = 1'b0;
    logic [9:0]  hold_prev = '0;

    assign m_tready = toggle_en ? tgl : tready_man;

    eth_rx_ext_fifo_shim #(.DEPTH(64), .DROP_BAD_FRAME(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .status_overflow(ovf), .status_bad_frame(bad), .status_good_frame(good)
`ifdef ETH_RX_SHIM_STATS_EN
        , .stat_good_frames(st_good), .stat_drop_frames(st_drop)
`endif
    );

    eth_rx_ext_fifo_shim #(.DEPTH(2048), .DROP_BAD_FRAME(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid_b), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(1'b1),
        .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
        .status_overflow(b_ovf), .status_bad_frame(b_bad), .status_good_frame(b_good)
`ifdef ETH_RX_SHIM_STATS_EN
        , .stat_good_frames(b_st_good), .stat_drop_frames(b_st_drop)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        tgl <= ~tgl;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle observation of both instances: scoreboard pops, AXIS hold rules, pulse counts
    task automatic sample();
        logic [9:0] exp_w;
        logic [9:0] obs_w;
        if (!rst_n) begin
            stall_prev = 1'b0;
            vld_prev   = 1'b0;
            return;
        end
        obs_w = {m_tlast, m_tuser, m_tdata};
        if (stall_prev) begin
            check("axis_hold_valid", 32'(m_tvalid), 32'd1);
            check("axis_hold_word", 32'(obs_w), 32'(hold_prev));
        end
        if (m_tvalid && !vld_prev) rise_cyc = cyc;
        if (m_tvalid && m_tready) begin
            check("sb_has_expected_beat", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("out_word", 32'(obs_w), 32'(exp_w));
            end
        end
        stall_prev = m_tvalid && !m_tready;
        hold_prev  = obs_w;
        vld_prev   = m_tvalid;
        if (ovf) begin
            n_ovf++;
            ovf_cyc = cyc;
        end
        if (bad)      n_bad++;
        if (good)     n_good++;
        if (b_tvalid) b_beats++;
        if (b_bad)    b_bad_n++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int len, input logic [7:0] base, input logic user,
                        input bit to_b, input bit push, input int mark);
        for (int i = 0; i < len; i++) begin
            s_tdata    = base + 8'(i);
            s_tlast    = (i == len - 1);
            s_tuser    = user && (i == len - 1);
            s_tvalid   = 1'b1;
            s_tvalid_b = to_b;
            if (i == mark) mark_cyc = cyc;
            if (i == len - 1) tlast_cyc = cyc;
            if (push) sb.push_back({s_tlast, s_tuser, s_tdata});
            tick();
        end
        s_tvalid   = 1'b0;
        s_tvalid_b = 1'b0;
        s_tlast    = 1'b0;
        s_tuser    = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 3000) begin
            tick();
            k++;
        end
        repeat (4) tick();
        check({tag, "_drained"}, 32'(sb.size()), 32'd0);
        check({tag, "_idle_valid"}, 32'(m_tvalid), 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_tuser", 32'(m_tuser), 32'd0);
        check("rst_status", 32'({ovf, bad, good}), 32'd0);
`ifdef ETH_RX_SHIM_STATS_EN
        check("rst_stat_good", st_good, 32'd0);
        check("rst_stat_drop", st_drop, 32'd0);
`endif
        rst_n = 1'b1;
        tready_man = 1'b1;
        tick();

        // 1: plain 64-byte frame, latency from input tlast to first tvalid
        rise_cyc = -1;
        send(64, 8'h00, 1'b0, 1'b0, 1'b1, -1);
        wait_drain("t1");
        check("t1_first_valid_latency", 32'(rise_cyc - tlast_cyc), 32'd3);
        check("t1_good_pulses", 32'(n_good), 32'd1);
        check("t1_bad_pulses", 32'(n_bad), 32'd0);

        // 2: bad frame, kept by the main instance and discarded by dut_b
        send(20, 8'h40, 1'b1, 1'b1, 1'b1, -1);
        wait_drain("t2");
        check("t2_bad_pulses", 32'(n_bad), 32'd1);
        check("t2_good_pulses", 32'(n_good), 32'd1);
        check("t2_dropbad_no_output", 32'(b_beats), 32'd0);
        check("t2_dropbad_bad_pulse", 32'(b_bad_n), 32'd1);

        // 3: two back-to-back 40-byte frames into a stalled 64-byte buffer
        tready_man = 1'b0;
        send(40, 8'h80, 1'b0, 1'b0, 1'b1, -1);
        send(40, 8'hC0, 1'b0, 1'b0, 1'b0, 24);
        repeat (2) tick();
        check("t3_overflow_count", 32'(n_ovf), 32'd1);
        check("t3_overflow_on_byte25", 32'(ovf_cyc - mark_cyc), 32'd1);
        check("t3_stalled_valid", 32'(m_tvalid), 32'd1);
        tready_man = 1'b1;
        wait_drain("t3a");
        send(20, 8'h10, 1'b0, 1'b0, 1'b1, -1);
        wait_drain("t3b");
        check("t3_good_pulses", 32'(n_good), 32'd3);

        // 4: frame one byte longer than the buffer, then one exactly DEPTH long
        send(65, 8'h00, 1'b0, 1'b0, 1'b0, 64);
        repeat (2) tick();
        check("t4_overflow_count", 32'(n_ovf), 32'd2);
        check("t4_overflow_on_byte65", 32'(ovf_cyc - mark_cyc), 32'd1);
        send(64, 8'h55, 1'b0, 1'b0, 1'b1, -1);
        wait_drain("t4");
        check("t4_good_pulses", 32'(n_good), 32'd4);

        // 5: eight frames with tready toggling every clock
        toggle_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            send(4 + f, 8'(f * 16), 1'b0, 1'b0, 1'b1, -1);
            repeat (4) tick();
        end
        wait_drain("t5");
        toggle_en = 1'b0;
        tready_man = 1'b1;
        check("t5_good_pulses", 32'(n_good), 32'd12);
        check("t5_overflow_count", 32'(n_ovf), 32'd2);
`ifdef ETH_RX_SHIM_STATS_EN
        check("stat_good_before_rst", st_good, 32'd12);
        check("stat_drop_before_rst", st_drop, 32'd2);
        check("b_stat_drop", b_st_drop, 32'd1);
        check("b_stat_good", b_st_good, 32'd0);
`endif

        // 6: reset pulse while a frame is streaming out
        send(30, 8'h20, 1'b0, 1'b0, 1'b1, -1);
        k = 0;
        while (!m_tvalid && k < 50) begin
            tick();
            k++;
        end
        check("t6_output_started", 32'(m_tvalid), 32'd1);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("t6_async_clear_valid", 32'(m_tvalid), 32'd0);
        sb.delete();
        tick();
`ifdef ETH_RX_SHIM_STATS_EN
        check("t6_stat_good_rst", st_good, 32'd0);
        check("t6_stat_drop_rst", st_drop, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("t6_valid_after_rst", 32'(m_tvalid), 32'd0);
        send(10, 8'h30, 1'b0, 1'b0, 1'b1, -1);
        wait_drain("t6");
        check("t6_good_pulses", 32'(n_good), 32'd14);
`ifdef ETH_RX_SHIM_STATS_EN
        check("t6_stat_good_after", st_good, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
